// File: rtl/logic_gate_pipe_if.sv
// Handshake bundle for logic_gate_pipe: operand side (in_*) and result side (out_*, rslt*).
// The block itself uses the slave modport; whatever drives operands and drains results uses master.
interface logic_gate_pipe_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] port_a;
    logic [WIDTH-1:0] port_b;
    logic [2:0]       op_sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] rslt;
    logic             rslt_zero;
    logic             rslt_par;

    modport master (
        output in_valid, port_a, port_b, op_sel, out_ready,
        input  in_ready, out_valid, rslt, rslt_zero, rslt_par
    );

    modport slave (
        input  in_valid, port_a, port_b, op_sel, out_ready,
        output in_ready, out_valid, rslt, rslt_zero, rslt_par
    );
endinterface

// File: rtl/logic_gate_pipe.sv
// Bitwise logic unit behind a 2-entry skid buffer with a saturating accept counter.
// Define LOGIC_GATE_PIPE_PARITY_EN to carry a per-entry parity bit out on rslt_par.
module logic_gate_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    logic_gate_pipe_if.slave     bus,
    output logic [CNT_W-1:0]     op_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             in_xfer;
    logic             out_xfer;
    logic             load_main_new;
    logic             load_main_skid;
    logic             load_skid;
    logic [WIDTH-1:0] new_rslt;

    function automatic logic [WIDTH-1:0] compute(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [2:0]       op
    );
        case (op)
            3'b000:  compute = a & b;
            3'b001:  compute = a | b;
            3'b010:  compute = a ^ b;
            3'b011:  compute = ~a;
            3'b100:  compute = ~(a & b);
            3'b101:  compute = ~(a | b);
            3'b110:  compute = ~(a ^ b);
            default: compute = a;
        endcase
    endfunction

    assign in_xfer  = bus.in_valid & in_ready_q;
    assign out_xfer = out_valid_q & bus.out_ready;
    assign new_rslt = compute(bus.port_a, bus.port_b, bus.op_sel);

    // Buffer control: decides which register loads what; the data paths below follow these enables.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
        state_d        = state_q;
        load_main_new  = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    load_main_new = 1'b1;
                    state_d       = ONE;
                end
            end
            ONE: begin
                case ({in_xfer, out_xfer})
                    2'b10: begin
                        load_skid = 1'b1;
                        state_d   = FULL;
                    end
                    2'b01:   state_d = EMPTY;
                    2'b11:   load_main_new = 1'b1;
                    default: state_d = ONE;
                endcase
            end
            FULL: begin
                if (out_xfer) begin
                    load_main_skid = 1'b1;
                    state_d        = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (load_main_new)  main_d = new_rslt;
        if (load_main_skid) main_d = skid_q;
        if (load_skid)      skid_d = new_rslt;

        // Handshake flags are registered from the next state so in_ready never sees out_ready combinationally.
        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);

        cnt_d = cnt_q;
        if (in_xfer && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge sys_clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (sys_rst) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

`ifdef LOGIC_GATE_PIPE_PARITY_EN
    logic main_par_q, main_par_d;
    logic skid_par_q, skid_par_d;

    always_comb begin
        main_par_d = main_par_q;
        skid_par_d = skid_par_q;
        if (load_main_new)  main_par_d = ^new_rslt;
        if (load_main_skid) main_par_d = skid_par_q;
        if (load_skid)      skid_par_d = ^new_rslt;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            main_par_q <= 1'b0;
            skid_par_q <= 1'b0;
        end else begin
            main_par_q <= main_par_d;
            skid_par_q <= skid_par_d;
        end
    end

    assign bus.rslt_par = main_par_q;
`else
    assign bus.rslt_par = 1'b0;
`endif

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.rslt      = main_q;
    assign bus.rslt_zero = ~|main_q;
    assign op_cnt        = cnt_q;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Self-checking bench for logic_gate_pipe: vector table, stall/reset sequences,
// randomized handshake against a queue model, and a narrow-counter saturation instance.
module tb_logic_gate_pipe;

    logic sys_clk = 1'b0;
    logic sys_rst;
    logic [15:0] op_cnt8;
    logic [3:0]  op_cnt4;

    always #5 sys_clk = ~sys_clk;

    logic_gate_pipe_if #(.WIDTH(8)) bus8 ();
    logic_gate_pipe_if #(.WIDTH(8)) bus4 ();

    logic_gate_pipe #(.WIDTH(8), .CNT_W(16)) u_dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus8.slave),
        .op_cnt  (op_cnt8)
    );

    logic_gate_pipe #(.WIDTH(8), .CNT_W(4)) u_dut4 (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus4.slave),
        .op_cnt  (op_cnt4)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [7:0] exp;
    } vec_t;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic logic [7:0] ref_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        case (op)
            3'd0: ref_op = a & b;
            3'd1: ref_op = a | b;
            3'd2: ref_op = a ^ b;
            3'd3: ref_op = ~a;
            3'd4: ref_op = ~(a & b);
            3'd5: ref_op = ~(a | b);
            3'd6: ref_op = ~(a ^ b);
            default: ref_op = a;
        endcase
    endfunction

    function automatic logic exp_par(input logic [7:0] r);
`ifdef LOGIC_GATE_PIPE_PARITY_EN
        exp_par = ^r;
`else
        exp_par = 1'b0;
`endif
    endfunction

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        bus8.in_valid = v;
        bus8.port_a   = a;
        bus8.port_b   = b;
        bus8.op_sel   = op;
    endtask

    task automatic do_reset();
        drive(1'b0, 8'h00, 8'h00, 3'd0);
        bus8.out_ready = 1'b0;
        sys_rst = 1'b1;
        tick();
        tick();
        sys_rst = 1'b0;
    endtask

    task automatic check_out(input string name, input logic [7:0] exp);
        check({name, "_valid"}, bus8.out_valid, 1'b1);
        check({name, "_rslt"},  bus8.rslt, exp);
        check({name, "_zero"},  bus8.rslt_zero, exp == 8'h00);
        check({name, "_par"},   bus8.rslt_par, exp_par(exp));
    endtask

    vec_t vecs [10];

    initial begin
        logic [7:0] q [$];
        logic [7:0] ra, rb;
        logic [2:0] rop;
        logic       iv, ordy, in_x, out_x;
        int         sent, cycles;

        vecs[0] = '{8'hF0, 8'h3C, 3'd0, 8'h30};
        vecs[1] = '{8'hA5, 8'h0F, 3'd0, 8'h05};
        vecs[2] = '{8'hA5, 8'h0F, 3'd1, 8'hAF};
        vecs[3] = '{8'hA5, 8'h0F, 3'd2, 8'hAA};
        vecs[4] = '{8'hA5, 8'h0F, 3'd3, 8'h5A};
        vecs[5] = '{8'hA5, 8'h0F, 3'd4, 8'hFA};
        vecs[6] = '{8'hA5, 8'h0F, 3'd5, 8'h50};
        vecs[7] = '{8'hA5, 8'h0F, 3'd6, 8'h55};
        vecs[8] = '{8'hA5, 8'h0F, 3'd7, 8'hA5};
        vecs[9] = '{8'h00, 8'h00, 3'd2, 8'h00};

        bus4.in_valid = 1'b0;
        bus4.port_a   = 8'h00;
        bus4.port_b   = 8'h00;
        bus4.op_sel   = 3'd0;
        bus4.out_ready = 1'b0;

        // Reset values
        do_reset();
        check("rst_out_valid", bus8.out_valid, 1'b0);
        check("rst_in_ready",  bus8.in_ready, 1'b1);
        check("rst_rslt",      bus8.rslt, 8'h00);
        check("rst_zero",      bus8.rslt_zero, 1'b1);
        check("rst_par",       bus8.rslt_par, 1'b0);
        check("rst_op_cnt",    op_cnt8, 16'd0);

        // Back-to-back vector table with a free-running sink: one result per cycle, no bubbles
        bus8.out_ready = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) begin
                check_out($sformatf("vec%0d", k - 1), vecs[k-1].exp);
                check($sformatf("vec%0d_cnt", k - 1), op_cnt8, k);
            end
            if (k < 10) begin
                drive(1'b1, vecs[k].a, vecs[k].b, vecs[k].op);
                check($sformatf("vec%0d_in_ready", k), bus8.in_ready, 1'b1);
            end else begin
                drive(1'b0, 8'h00, 8'h00, 3'd0);
            end
            tick();
        end
        check("vec_drained", bus8.out_valid, 1'b0);

        // Stalled sink: two accepted, FULL, then drain in order and accept the third
        do_reset();
        bus8.out_ready = 1'b0;
        drive(1'b1, 8'h01, 8'h02, 3'd1);
        tick();
        check("stall_ready1", bus8.in_ready, 1'b1);
        check_out("stall_first", 8'h03);
        drive(1'b1, 8'h10, 8'h20, 3'd1);
        tick();
        drive(1'b1, 8'h44, 8'h00, 3'd7);
        check("stall_full", bus8.in_ready, 1'b0);
        check_out("stall_hold0", 8'h03);
        tick();
        check("stall_full2", bus8.in_ready, 1'b0);
        check_out("stall_hold1", 8'h03);
        check("stall_cnt2", op_cnt8, 16'd2);
        bus8.out_ready = 1'b1;
        tick();
        check("stall_ready_back", bus8.in_ready, 1'b1);
        check_out("stall_second", 8'h30);
        tick();
        drive(1'b0, 8'h00, 8'h00, 3'd0);
        check_out("stall_third", 8'h44);
        check("stall_cnt3", op_cnt8, 16'd3);
        tick();
        check("stall_empty", bus8.out_valid, 1'b0);

        // Reset while FULL, with an input offered during the reset cycle
        do_reset();
        drive(1'b1, 8'hC3, 8'h00, 3'd7);
        tick();
        drive(1'b1, 8'h3C, 8'h00, 3'd7);
        tick();
        check("mid_full", bus8.in_ready, 1'b0);
        sys_rst = 1'b1;
        drive(1'b1, 8'h99, 8'h00, 3'd7);
        tick();
        sys_rst = 1'b0;
        check("mid_out_valid", bus8.out_valid, 1'b0);
        check("mid_in_ready",  bus8.in_ready, 1'b1);
        check("mid_op_cnt",    op_cnt8, 16'd0);
        check("mid_rslt",      bus8.rslt, 8'h00);
        bus8.out_ready = 1'b1;
        drive(1'b1, 8'h77, 8'h00, 3'd7);
        tick();
        drive(1'b0, 8'h00, 8'h00, 3'd0);
        check_out("mid_first", 8'h77);
        check("mid_cnt1", op_cnt8, 16'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("mid_no_stale%0d", k), bus8.out_valid, 1'b0);
        end

        // Random in_valid/out_ready against a queue model
        do_reset();
        sent   = 0;
        cycles = 0;
        while ((sent < 1000 || q.size() > 0) && cycles < 20000) begin
            check("rnd_valid", bus8.out_valid, q.size() > 0);
            check("rnd_ready", bus8.in_ready, q.size() < 2);
            if (bus8.out_valid && q.size() > 0) begin
                check("rnd_rslt", bus8.rslt, q[0]);
                check("rnd_par",  bus8.rslt_par, exp_par(q[0]));
                check("rnd_zero", bus8.rslt_zero, q[0] == 8'h00);
            end
            iv   = (sent < 1000) && ($urandom_range(0, 1) == 1);
            ordy = ($urandom_range(0, 1) == 1);
            ra   = 8'($urandom_range(0, 255));
            rb   = 8'($urandom_range(0, 255));
            rop  = 3'($urandom_range(0, 7));
            drive(iv, ra, rb, rop);
            bus8.out_ready = ordy;
            in_x  = iv && bus8.in_ready;
            out_x = bus8.out_valid && ordy;
            tick();
            if (out_x) void'(q.pop_front());
            if (in_x) begin
                q.push_back(ref_op(ra, rb, rop));
                sent++;
            end
            cycles++;
        end
        check("rnd_in_budget", cycles < 20000, 1'b1);
        drive(1'b0, 8'h00, 8'h00, 3'd0);
        check("rnd_op_cnt", op_cnt8, 16'd1000);

        // Narrow counter saturates at 15; zero result flag
        bus4.out_ready = 1'b1;
        bus4.in_valid  = 1'b1;
        bus4.port_a    = 8'h00;
        bus4.port_b    = 8'h00;
        bus4.op_sel    = 3'd2;
        for (int k = 1; k <= 20; k++) begin
            tick();
            check($sformatf("sat_cnt%0d", k), op_cnt4, (k > 15) ? 15 : k);
        end
        bus4.in_valid = 1'b0;
        check("sat_valid", bus4.out_valid, 1'b1);
        check("sat_rslt",  bus4.rslt, 8'h00);
        check("sat_zero",  bus4.rslt_zero, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/logic_gate_pipe.md
LOGIC_GATE_PIPE -- requirements
Module: logic_gate_pipe

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits, legal range 1..32.
REQ-002 Parameter CNT_W, default 16: width of the accepted-operation counter.
REQ-003 sys_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 sys_rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  upstream operand set valid.
REQ-006 in_ready  output  1  block can accept an operand set; driven from a register, never combinationally from out_ready.
REQ-007 port_a  input  WIDTH  operand A.
REQ-008 port_b  input  WIDTH  operand B.
REQ-009 op_sel  input  3  operation code, sampled with the operands.
REQ-010 out_valid  output  1  rslt is valid.
REQ-011 out_ready  input  1  downstream accepts rslt.
REQ-012 rslt  output  WIDTH  operation result.
REQ-013 rslt_zero  output  1  high when rslt is all zeros; qualified by out_valid.
REQ-014 rslt_par  output  1  XOR-reduction of rslt; see Configuration.
REQ-015 op_cnt  output  CNT_W  count of accepted operand sets, saturating.

Function
REQ-016 Operations are bitwise:
- 000 A&B
- 001 A|B
- 010 A^B
- 011 ~A
- 100 ~(A&B)
- 101 ~(A|B)
- 110 ~(A^B)
- 111 A (pass)
REQ-017 An input transfer occurs on a cycle with in_valid=1 and in_ready=1; an output transfer occurs on a cycle with out_valid=1 and out_ready=1.
REQ-018 The result is computed at acceptance and stored; minimum latency is 1 cycle, so the result appears on rslt the cycle after acceptance.
REQ-019 Storage is a 2-entry skid buffer: a main register drives the outputs, and a skid register holds the overflow.
REQ-020 The buffer state machine has three states: EMPTY (0 entries), ONE (1 entry) and FULL (2 entries).
REQ-021 Transitions:
- EMPTY + input transfer -> ONE.
- ONE + input transfer only -> FULL.
- ONE + output transfer only -> EMPTY.
- ONE + both transfers -> ONE.
- FULL + output transfer -> ONE, and the skid entry moves to the main register in the same edge.
REQ-022 out_valid=1 in ONE and FULL; in_ready=0 only in FULL.
REQ-023 Results are delivered strictly in acceptance order; no result is lost or duplicated under any in_valid/out_ready pattern.
REQ-024 rslt, rslt_zero and rslt_par hold steady while out_valid=1 and out_ready=0.
REQ-025 op_cnt increments by 1 on each input transfer and saturates at all-ones; it never wraps.
REQ-026 Operands and op_sel are don't-care when in_valid=0.

Reset
REQ-027 While sys_rst=1 at a clock edge, the block enters EMPTY and takes these values:
- out_valid=0
- in_ready=1
- rslt=0
- rslt_zero=1
- rslt_par=0
- op_cnt=0
REQ-028 A reset asserted mid-operation discards all buffered results.
REQ-029 An input offered in the reset cycle is not accepted and is not counted.
REQ-030 The first input transfer is possible in the cycle after sys_rst deasserts.

Configuration
REQ-031 Macro LOGIC_GATE_PIPE_PARITY_EN defined: rslt_par is stored per entry as the XOR-reduction of the result and travels with it through the buffer.
REQ-032 Macro LOGIC_GATE_PIPE_PARITY_EN undefined: the parity logic is absent, rslt_par is tied to 0, and all other behaviour is identical.

Verification
REQ-033 WIDTH=8, out_ready=1, one input A=0xF0, B=0x3C, op=000 -> next cycle out_valid=1, rslt=0x30, rslt_zero=0, rslt_par=0 (with macro), op_cnt=1.
REQ-034 Sweep op 000..111 with A=0xA5, B=0x0F back-to-back, out_ready=1 -> rslt sequence 0x05, 0xAF, 0xAA, 0x5A, 0xFA, 0x50, 0x55, 0xA5, one per cycle, no bubbles.
REQ-035 out_ready=0 with 3 inputs offered -> 2 accepted, then in_ready=0 (FULL). Raise out_ready -> both results drain in order and the third input is then accepted.
REQ-036 Random in_valid/out_ready at 50% each, 1000 transfers -> output stream equals the reference-model stream, and op_cnt=1000.
REQ-037 Assert sys_rst for 1 cycle while FULL -> next cycle out_valid=0, in_ready=1, op_cnt=0, and no stale result ever appears.
REQ-038 CNT_W=4, 20 transfers -> op_cnt stops at 15; A=B=0x00 with op=010 -> rslt_zero=1.
